// File: rtl/corelet_pkg.sv
// corelet_pkg: shared types and constants for the corelet weight-stationary sequencer.
//   state_e  : sequencer FSM encoding
//   INST_*   : MAC instruction words (bit2 = OS mode, bit1 = execute, bit0 = kernel load)
//   CNT_W    : width of the phase/vector counters
package corelet_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KLOAD,
    S_KPUSH,
    S_SETTLE,
    S_ALOAD,
    S_EXEC,
    S_DRAIN,
    S_FIN
  } state_e;

  localparam logic [2:0] INST_IDLE  = 3'b000;
  localparam logic [2:0] INST_KLOAD = 3'b001;
  localparam logic [2:0] INST_EXEC  = 3'b010;

  localparam int CNT_W = 16;

endpackage

// File: rtl/corelet_seq_fill.sv
// corelet_seq_fill: throttled xmem -> L0 read issuer, shared by kernel and activation loads.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   en_i                phase active; deasserting clears the vector index
//   count_i, base_i     vectors to move and their first xmem address
//   l0_full_i           L0 back-pressure
//   xmem_cen_o          active-low read strobe
//   xmem_addr_o         read address (0 when no read is issued)
//   l0_wr_o             L0 write, one cycle after each read
//   fill_done_o         high on the cycle of the last L0 write
module corelet_seq_fill
  import corelet_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              l0_full_i,
  output logic              xmem_cen_o,
  output logic [ADDR_W-1:0] xmem_addr_o,
  output logic              l0_wr_o,
  output logic              fill_done_o
);

  logic [CNT_W-1:0] idx_q, idx_d;
  logic             wr_q, wr_d;
  logic             issue;

  // Skipping the cycle in which the previous read lands in L0 keeps only one
  // read in flight, so l0_full seen at issue time is always current.
  always_comb begin
    issue = en_i && !l0_full_i && !wr_q && (idx_q < count_i);
    idx_d = idx_q;
    if (!en_i)
      idx_d = '0;
    else if (issue)
      idx_d = idx_q + CNT_W'(1);
    wr_d = issue;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
      wr_q  <= 1'b0;
    end else begin
      idx_q <= idx_d;
      wr_q  <= wr_d;
    end
  end

  assign xmem_cen_o  = ~issue;
  assign xmem_addr_o = issue ? base_i + ADDR_W'(idx_q) : '0;
  assign l0_wr_o     = wr_q;
  assign fill_done_o = en_i && wr_q && (idx_q == count_i);

endmodule

// File: rtl/corelet_seq.sv
// corelet_seq: weight-stationary sequencer for the corelet datapath (L0, MAC array, OFIFO).
// For each of N_KIJ kernel positions: kernel load, kernel push, settle, activation load,
// execute, then drain the OFIFO into pmem.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start                      run request, honoured only in IDLE
//   l0_full, ofifo_valid       corelet status
//   xmem_cen/wen/addr          activation/weight SRAM read port (wen fixed high)
//   pmem_cen/wen/addr          psum SRAM write port
//   l0_wr, l0_rd, inst_w       L0 strobes and MAC instruction
//   ofifo_rd                   OFIFO pop
//   busy, done, kij            run status
// Build option CORELET_SEQ_PERF_EN adds perf_cycles (busy cycles) and perf_stall
// (ALOAD cycles with l0_full plus DRAIN cycles without ofifo_valid).
//
// state  | meaning
// IDLE   | waiting for start
// KLOAD  | weights for kij -> L0
// KPUSH  | L0 -> MAC array with kernel-load instruction, col cycles
// SETTLE | quiet cycles while weights propagate
// ALOAD  | activations -> L0
// EXEC   | L0 -> MAC array with execute instruction, N_ACT cycles
// DRAIN  | OFIFO pop then pmem write, N_ACT times
// FIN    | done pulse
module corelet_seq
  import corelet_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int inst_bw = 3,
  parameter int N_ACT   = 36,
  parameter int N_KIJ   = 9,
  parameter int ADDR_W  = 11,
  parameter int W_BASE  = 1024,
  parameter int SETTLE  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               l0_full,
  input  logic               ofifo_valid,
  output logic               xmem_cen,
  output logic               xmem_wen,
  output logic [ADDR_W-1:0]  xmem_addr,
  output logic               pmem_cen,
  output logic               pmem_wen,
  output logic [ADDR_W-1:0]  pmem_addr,
  output logic               l0_wr,
  output logic               l0_rd,
  output logic [inst_bw-1:0] inst_w,
  output logic               ofifo_rd,
  output logic               busy,
  output logic               done,
  output logic [3:0]         kij
`ifdef CORELET_SEQ_PERF_EN
  ,
  output logic [31:0]        perf_cycles,
  output logic [31:0]        perf_stall
`endif
);

  // Weights must have crossed the whole array before activations follow.
  if (SETTLE < row + col) begin : g_settle_too_short
    $error("SETTLE must be at least row+col");
  end

  state_e           state_q, state_d;
  logic [3:0]       kij_q, kij_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] o_q, o_d;
  logic             pop_q;
  logic             fill_en, fill_done;
  logic [CNT_W-1:0] fill_count;
  logic [ADDR_W-1:0] fill_base;

  assign fill_en    = (state_q == S_KLOAD) || (state_q == S_ALOAD);
  assign fill_count = (state_q == S_KLOAD) ? CNT_W'(col) : CNT_W'(N_ACT);
  assign fill_base  = (state_q == S_KLOAD) ? ADDR_W'(W_BASE + int'(kij_q) * col) : '0;

  corelet_seq_fill #(.ADDR_W(ADDR_W)) u_fill (
    .clk        (clk),
    .reset      (reset),
    .en_i       (fill_en),
    .count_i    (fill_count),
    .base_i     (fill_base),
    .l0_full_i  (l0_full),
    .xmem_cen_o (xmem_cen),
    .xmem_addr_o(xmem_addr),
    .l0_wr_o    (l0_wr),
    .fill_done_o(fill_done)
  );

  // Pops and writes alternate, so with no pop pending o_q equals pops issued.
  assign ofifo_rd = (state_q == S_DRAIN) && ofifo_valid && !pop_q && (o_q < CNT_W'(N_ACT));

  always_comb begin
    state_d = state_q;
    kij_d   = kij_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_KLOAD;
          kij_d   = '0;
        end
      end
      S_KLOAD: begin
        if (fill_done) begin
          state_d = S_KPUSH;
          cnt_d   = CNT_W'(col - 1);
        end
      end
      S_KPUSH: begin
        if (cnt_q == '0) begin
          state_d = S_SETTLE;
          cnt_d   = CNT_W'(SETTLE - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_ALOAD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_ALOAD: begin
        if (fill_done) begin
          state_d = S_EXEC;
          cnt_d   = CNT_W'(N_ACT - 1);
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          state_d = S_DRAIN;
          o_d     = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (pop_q) begin
          o_d = o_q + CNT_W'(1);
          if (o_q == CNT_W'(N_ACT - 1)) begin
            o_d = '0;
            if (kij_q == 4'(N_KIJ - 1)) begin
              state_d = S_FIN;
            end else begin
              state_d = S_KLOAD;
              kij_d   = kij_q + 4'd1;
            end
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      kij_q   <= '0;
      cnt_q   <= '0;
      o_q     <= '0;
      pop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kij_q   <= kij_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      pop_q   <= ofifo_rd;
    end
  end

  assign xmem_wen  = 1'b1;
  assign pmem_cen  = ~pop_q;
  assign pmem_wen  = ~pop_q;
  assign pmem_addr = pop_q ? ADDR_W'(int'(kij_q) * N_ACT + int'(o_q)) : '0;
  assign l0_rd     = (state_q == S_KPUSH) || (state_q == S_EXEC);
  assign inst_w    = (state_q == S_KPUSH) ? inst_bw'(INST_KLOAD) :
                     (state_q == S_EXEC)  ? inst_bw'(INST_EXEC)  : inst_bw'(INST_IDLE);
  assign busy      = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done      = (state_q == S_FIN);
  assign kij       = kij_q;

`ifdef CORELET_SEQ_PERF_EN
  logic [31:0] perf_cycles_q, perf_stall_q;
  logic        stall_cyc;

  assign stall_cyc = ((state_q == S_ALOAD) && l0_full) || ((state_q == S_DRAIN) && !ofifo_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (busy)      perf_cycles_q <= perf_cycles_q + 32'd1;
      if (stall_cyc) perf_stall_q  <= perf_stall_q + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_corelet_seq.sv
// Bench for corelet_seq with row=col=4, N_ACT=4, N_KIJ=2, SETTLE=8.
// A negedge monitor logs SRAM traffic and protocol events; each run is compared
// against address sequences and cycle budgets derived from the sequencing rules.
module tb_corelet_seq;
  localparam int ROW = 4, COL = 4, INST_BW = 3, N_ACT = 4, N_KIJ = 2;
  localparam int ADDR_W = 11, W_BASE = 1024, SETTLE = 8;

  logic clk = 1'b0;
  logic reset, start, l0_full, ofifo_valid;
  logic xmem_cen, xmem_wen, pmem_cen, pmem_wen, l0_wr, l0_rd, ofifo_rd, busy, done;
  logic [ADDR_W-1:0] xmem_addr, pmem_addr;
  logic [INST_BW-1:0] inst_w;
  logic [3:0] kij;
`ifdef CORELET_SEQ_PERF_EN
  logic [31:0] perf_cycles, perf_stall;
`endif

  corelet_seq #(
    .row(ROW), .col(COL), .inst_bw(INST_BW), .N_ACT(N_ACT), .N_KIJ(N_KIJ),
    .ADDR_W(ADDR_W), .W_BASE(W_BASE), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .l0_full(l0_full), .ofifo_valid(ofifo_valid),
    .xmem_cen(xmem_cen), .xmem_wen(xmem_wen), .xmem_addr(xmem_addr),
    .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_addr(pmem_addr),
    .l0_wr(l0_wr), .l0_rd(l0_rd), .inst_w(inst_w), .ofifo_rd(ofifo_rd),
    .busy(busy), .done(done), .kij(kij)
`ifdef CORELET_SEQ_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // monitor state
  int unsigned rd_q[$], pw_q[$], kp_runs[$], ex_runs[$], gaps[$];
  int viol, l0wr_cnt, done_cnt, busy_cnt, run_len, gap;
  int bp_events, bp_cycles, st_events, st_cycles;
  logic prev_read = 0, prev_pop = 0, prev_busy = 0;
  logic [2:0] run_inst;
  logic [ADDR_W-1:0] prev_addr = '0;
  bit gap_armed, act_wr_now, pw_now, bp_active, st_active;

  task clear_logs();
    rd_q.delete(); pw_q.delete(); kp_runs.delete(); ex_runs.delete(); gaps.delete();
    viol = 0; l0wr_cnt = 0; done_cnt = 0; busy_cnt = 0; run_len = 0; gap = 0;
    bp_events = 0; bp_cycles = 0; st_events = 0; st_cycles = 0;
    run_inst = 3'b000; gap_armed = 0; bp_active = 0; st_active = 0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_read = 0; prev_pop = 0; prev_busy = 0;
      run_inst = 3'b000; run_len = 0; gap_armed = 0; act_wr_now = 0; pw_now = 0;
    end else begin
      pw_now     = !pmem_cen;
      act_wr_now = l0_wr && (prev_addr < ADDR_W'(W_BASE));
      if (!xmem_cen) begin
        rd_q.push_back(int'(xmem_addr));
        if (l0_full || l0_wr) viol++;
      end
      if (l0_wr !== prev_read) viol++;
      if (l0_wr) l0wr_cnt++;
      if (xmem_wen !== 1'b1) viol++;
      if (pmem_wen !== pmem_cen) viol++;
      if (!pmem_cen) begin
        pw_q.push_back(int'(pmem_addr));
        if (int'(kij) != int'(pmem_addr) / N_ACT) viol++;
      end
      if ((!pmem_cen) !== prev_pop) viol++;
      if (ofifo_rd && (!ofifo_valid || prev_pop)) viol++;
      if (l0_rd !== (inst_w == 3'b001 || inst_w == 3'b010)) viol++;
      if (!(inst_w inside {3'b000, 3'b001, 3'b010})) viol++;
      if (run_inst == 3'b001 && inst_w != 3'b001) begin
        gap_armed = 1; gap = 0;
      end
      if (gap_armed) begin
        if (xmem_cen && !l0_wr && !l0_rd && inst_w == 3'b000 && !ofifo_rd && pmem_cen) gap++;
        else begin gaps.push_back(gap); gap_armed = 0; end
      end
      if (inst_w === run_inst) run_len++;
      else begin
        if (run_inst == 3'b001) kp_runs.push_back(run_len);
        else if (run_inst == 3'b010) ex_runs.push_back(run_len);
        run_inst = inst_w; run_len = 1;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (busy || !prev_busy) viol++;
      end
      if (bp_active) begin
        bp_cycles++;
        if (!xmem_cen || l0_wr) bp_events++;
      end
      if (st_active) begin
        st_cycles++;
        if (ofifo_rd || !pmem_cen) st_events++;
      end
      prev_read = !xmem_cen; prev_pop = ofifo_rd; prev_busy = busy;
      if (!xmem_cen) prev_addr = xmem_addr;
    end
  end

  task automatic chk_rst(input string p);
    chk({p, "_xmem_cen"}, xmem_cen, 1);
    chk({p, "_xmem_wen"}, xmem_wen, 1);
    chk({p, "_xmem_addr"}, xmem_addr, 0);
    chk({p, "_pmem_cen"}, pmem_cen, 1);
    chk({p, "_pmem_wen"}, pmem_wen, 1);
    chk({p, "_pmem_addr"}, pmem_addr, 0);
    chk({p, "_l0_wr"}, l0_wr, 0);
    chk({p, "_l0_rd"}, l0_rd, 0);
    chk({p, "_inst_w"}, inst_w, 0);
    chk({p, "_ofifo_rd"}, ofifo_rd, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_kij"}, kij, 0);
`ifdef CORELET_SEQ_PERF_EN
    chk({p, "_perf_cycles"}, perf_cycles, 0);
    chk({p, "_perf_stall"}, perf_stall, 0);
`endif
  endtask

  // p_full/p_vld/p_start are per-cycle percentages; bp_len/st_len force a
  // back-pressure window in ALOAD / a valid-low window in DRAIN.
  task automatic do_run(input string tag, input int p_full, input int p_vld, input int p_start,
                        input int bp_len, input int st_len, input bit timed);
    int cyc, bp_left, st_left, bad;
    bit bp_pend, st_pend, timeout;
    int unsigned exp_rd[$], exp_pw[$];
    clear_logs();
    bp_pend = (bp_len > 0); st_pend = (st_len > 0); bp_left = 0; st_left = 0;
    @(posedge clk); #1;
    start = 1; l0_full = 0; ofifo_valid = 1;
    @(negedge clk);
    chk({tag, "_busy_at_start"}, busy, 0);
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk({tag, "_busy_after_start"}, busy, 1);
    timeout = 1;
    for (cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) begin timeout = 0; break; end
      l0_full     = (p_full > 0) && ($urandom_range(99) < p_full);
      ofifo_valid = ($urandom_range(99) < p_vld);
      start       = busy && ($urandom_range(99) < p_start);
      if (bp_pend && act_wr_now) begin bp_pend = 0; bp_left = bp_len; end
      bp_active = (bp_left > 0);
      if (bp_left > 0) begin l0_full = 1; bp_left--; end
      if (st_pend && pw_now) begin st_pend = 0; st_left = st_len; end
      st_active = (st_left > 0);
      if (st_left > 0) begin ofifo_valid = 0; st_left--; end
    end
    start = 0; l0_full = 0; ofifo_valid = 1; bp_active = 0; st_active = 0;
    repeat (4) @(negedge clk);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_idle_after"}, busy, 0);

    for (int k = 0; k < N_KIJ; k++) begin
      for (int i = 0; i < COL; i++) exp_rd.push_back(W_BASE + k * COL + i);
      for (int i = 0; i < N_ACT; i++) exp_rd.push_back(i);
    end
    for (int a = 0; a < N_KIJ * N_ACT; a++) exp_pw.push_back(a);

    chk({tag, "_rd_len"}, rd_q.size(), exp_rd.size());
    bad = 0;
    for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++) if (rd_q[i] != exp_rd[i]) bad++;
    chk({tag, "_rd_seq_bad"}, bad, 0);
    chk({tag, "_pw_len"}, pw_q.size(), exp_pw.size());
    bad = 0;
    for (int i = 0; i < exp_pw.size() && i < pw_q.size(); i++) if (pw_q[i] != exp_pw[i]) bad++;
    chk({tag, "_pw_seq_bad"}, bad, 0);

    chk({tag, "_kpush_runs"}, kp_runs.size(), N_KIJ);
    bad = 0;
    foreach (kp_runs[i]) if (kp_runs[i] != COL) bad++;
    chk({tag, "_kpush_len_bad"}, bad, 0);
    chk({tag, "_exec_runs"}, ex_runs.size(), N_KIJ);
    bad = 0;
    foreach (ex_runs[i]) if (ex_runs[i] != N_ACT) bad++;
    chk({tag, "_exec_len_bad"}, bad, 0);
    chk({tag, "_l0_wr_total"}, l0wr_cnt, N_KIJ * (COL + N_ACT));
    chk({tag, "_protocol_viol"}, viol, 0);

    if (timed) begin
      // each fill moves one vector per two cycles; each drain entry is pop + write
      chk({tag, "_busy_cycles"}, busy_cnt,
          N_KIJ * (2 * COL + COL + SETTLE + 2 * N_ACT + N_ACT + 2 * N_ACT));
      chk({tag, "_settle_gaps"}, gaps.size(), N_KIJ);
      bad = 0;
      foreach (gaps[i]) if (gaps[i] != SETTLE) bad++;
      chk({tag, "_settle_gap_bad"}, bad, 0);
    end
    if (bp_len > 0) begin
      chk({tag, "_bp_window"}, bp_cycles, bp_len);
      chk({tag, "_bp_activity"}, bp_events, 0);
    end
    if (st_len > 0) begin
      chk({tag, "_stall_window"}, st_cycles, st_len);
      chk({tag, "_stall_activity"}, st_events, 0);
    end
`ifdef CORELET_SEQ_PERF_EN
    chk({tag, "_perf_cycles"}, perf_cycles, busy_cnt);
    if (st_len > 0) chk({tag, "_perf_stall_min"}, perf_stall >= st_len, 1);
    if (bp_len > 0) chk({tag, "_perf_stall_bp"}, perf_stall >= bp_len, 1);
    if (timed && p_full == 0 && p_vld >= 100) chk({tag, "_perf_stall_zero"}, perf_stall, 0);
`endif
  endtask

  task automatic reset_in_exec();
    bit found;
    int seen_done, seen_busy;
    clear_logs();
    @(posedge clk); #1;
    start = 1; l0_full = 0; ofifo_valid = 1;
    @(posedge clk); #1;
    start = 0;
    found = 0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk);
      if (inst_w == 3'b010) found = 1;
    end
    chk("rexec_reached", found, 1);
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    chk("rexec_still_exec", inst_w, 3'b010);
    @(posedge clk); #1;
    l0_full = 1; ofifo_valid = 1;
    @(negedge clk);
    chk_rst("rexec");
    @(posedge clk); #1;
    reset = 0; l0_full = 0;
    seen_done = 0; seen_busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) seen_done++;
      if (busy) seen_busy++;
    end
    chk("rexec_no_done", seen_done + done_cnt, 0);
    chk("rexec_stays_idle", seen_busy, 0);
  endtask

  initial begin
    reset = 1; start = 0; l0_full = 0; ofifo_valid = 1;
    clear_logs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst("reset");
    @(posedge clk); #1;
    reset = 0;

    do_run("directed", 0, 100, 0, 0, 0, 1);
    do_run("backpressure", 0, 100, 0, 5, 0, 0);
    do_run("drain_stall", 0, 100, 0, 0, 10, 0);
    do_run("start_busy", 0, 100, 20, 0, 0, 1);
    reset_in_exec();
    for (int i = 0; i < 4; i++) do_run($sformatf("rand%0d", i), 30, 60, 5, 0, 0, 0);
    do_run("after_rand", 0, 100, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/corelet_seq.md
Name: corelet_seq

Overview:
- Weight-stationary (WS) sequencer for the corelet datapath (L0, MAC array, OFIFO).
- Drives the activation/weight SRAM (xmem) read port and the psum SRAM (pmem) write port.
- Drives L0 write/read strobes, MAC instruction bits and OFIFO read.
- Runs N_KIJ kernel positions per `start`. For each kij it performs: kernel load -> kernel settle -> activation load -> execute -> OFIFO drain to pmem.

Parameters:
- row, 8: MAC array rows (L0 width in lanes).
- col, 8: MAC array columns, which is also the number of weight vectors per kij.
- inst_bw, 3: instruction width. Bit [2] is OS mode (always 0 here), bit [1] is execute, bit [0] is kernel load.
- N_ACT, 36: activation vectors per kij. Must be no greater than the L0 depth.
- N_KIJ, 9: kernel positions.
- ADDR_W, 11: SRAM address width.
- W_BASE, 1024: xmem base address of weights.
- SETTLE, 16: idle cycles after kernel load (at least row+col).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when in IDLE.
- l0_full  in  1  from corelet.
- ofifo_valid  in  1  from corelet; at least one full column-row is available.
- xmem_cen  out  1  active-low chip enable; a read is issued when low.
- xmem_wen  out  1  constant 1 (read only).
- xmem_addr  out  ADDR_W  xmem read address.
- pmem_cen  out  1  active-low chip enable.
- pmem_wen  out  1  active-low write enable.
- pmem_addr  out  ADDR_W  pmem write address.
- l0_wr  out  1  L0 write; write data is the xmem data.
- l0_rd  out  1  L0 read into the MAC array.
- inst_w  out  inst_bw  MAC instruction.
- ofifo_rd  out  1  OFIFO pop.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at run end.
- kij  out  4  current kernel index.

Behaviour:
- Reset values: all outputs 0 except xmem_cen=1, pmem_cen=1, xmem_wen=1, pmem_wen=1. Counters are cleared and the FSM goes to IDLE.
- Reset mid-run aborts immediately. No done pulse is produced.
- SRAM read latency is 1 cycle. A read issued at cycle t is written to L0 at t+1 (l0_wr=1 at t+1).
- Throttled fill: a read is issued at t only when all of the following hold:
  - l0_full=0 at t;
  - l0_wr=0 at t;
  - the phase count is not yet exhausted.
  - This allows at most one read outstanding, so L0 never overflows. Peak rate is one vector per 2 cycles.
- FSM states:
  - IDLE: a `start` pulse moves to KLOAD with kij=0. `start` in any other state is ignored.
  - KLOAD: reads col vectors at W_BASE+kij*col+i into L0. After the last l0_wr, go to KPUSH.
  - KPUSH: l0_rd=1 and inst_w=001 for exactly col consecutive cycles, then go to SETTLE.
  - SETTLE: count SETTLE cycles with all strobes 0, then go to ALOAD.
  - ALOAD: reads N_ACT vectors at addresses 0..N_ACT-1, throttled as above. After the last l0_wr, go to EXEC.
  - EXEC: l0_rd=1 and inst_w=010 for exactly N_ACT cycles, then go to DRAIN.
  - DRAIN: repeat N_ACT times:
    - when ofifo_valid=1 and no pop was issued the previous cycle, pulse ofifo_rd;
    - the cycle after, assert pmem_cen=0 and pmem_wen=0 with pmem_addr=kij*N_ACT+o.
    - After the N_ACT-th write, go to KLOAD with kij+1, or to FIN if kij=N_KIJ-1.
  - FIN: done=1 for one cycle, then go to IDLE.
- inst_w is 000 in every state except KPUSH and EXEC.
- Address arithmetic is unsigned modulo 2^ADDR_W. The bench does not exercise overflow.
- ofifo_valid staying low stalls DRAIN indefinitely. There is no timeout.
- If ofifo_valid is low at the first drain cycle, the block waits without popping.

Optional Feature:
- Macro: CORELET_SEQ_PERF_EN.
- When defined, adds outputs perf_cycles[31:0] and perf_stall[31:0]:
  - perf_cycles counts busy cycles;
  - perf_stall counts ALOAD cycles blocked by l0_full plus DRAIN cycles with ofifo_valid=0.
  - Both clear on an accepted start, hold after done, and reset to 0.
- When undefined, the ports and logic are absent. Core behaviour is identical in both cases.

Decomposition:
- Package corelet_pkg holds:
  - FSM state encoding: IDLE, KLOAD, KPUSH, SETTLE, ALOAD, EXEC, DRAIN, FIN;
  - instruction constants INST_IDLE=000, INST_KLOAD=001, INST_EXEC=010.
- One natural sub-module: corelet_seq_fill, the throttled SRAM-to-L0 read issuer.
  - Inputs: count and base address.
  - Outputs: xmem_cen, xmem_addr, l0_wr, fill_done.
  - Reused by KLOAD and ALOAD.

Test Plan:
- Bench configuration for all scenarios: row=col=4, N_ACT=4, N_KIJ=2, SETTLE=8.
- Single run, l0_full=0, ofifo_valid=1:
  - xmem reads addresses 1024..1027, then 0..3 for kij=0;
  - then 1028..1031, then 0..3 for kij=1;
  - pmem writes addresses 0..7 in order;
  - done pulses exactly once; busy drops the same cycle as done.
- KPUSH/EXEC shape: inst_w=001 is held exactly 4 cycles and 010 exactly 4 cycles, with l0_rd coincident. Exactly 8 zero cycles separate them.
- Backpressure: hold l0_full=1 for 5 cycles during ALOAD. No xmem read and no l0_wr occur during those cycles, and exactly 4 l0_wr occur in total.
- Drain stall: ofifo_valid=0 for 10 cycles in DRAIN:
  - no ofifo_rd and no pmem write occur while it is low;
  - writes resume in order and the pmem address sequence is unchanged;
  - with CORELET_SEQ_PERF_EN defined, perf_stall is at least 10.
- Control edge cases:
  - reset asserted in EXEC: the next cycle shows all outputs at reset values and no done pulse;
  - start pulsed while busy: ignored, and the run completes normally.
